// File: rtl/layer0_input_packer.sv
// layer0_input_packer
// Collects NUM_FEATURES quantized features (one per stream beat) into a flat
// vector for the layer-0 neuron LUTs. An assembly register fills while the
// output register holds the previous vector. Malformed frames are dropped.
// They raise a sticky flag and are tallied in a saturating counter.
module layer0_input_packer #(
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_BITS    = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [FEAT_BITS-1:0]              s_data,
    input  logic                              s_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [NUM_FEATURES*FEAT_BITS-1:0] m_data,
    output logic                              frame_err,
    input  logic                              err_clr,
    output logic [ERR_CNT_W-1:0]              err_count
);

    localparam int VEC_W = NUM_FEATURES * FEAT_BITS;
    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + ERR_CNT_W'(1);
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [VEC_W-1:0]     asm_r;
    logic [VEC_W-1:0]     asm_nxt_s;
    logic [VEC_W-1:0]     m_data_r;
    logic                 m_valid_r;
    logic                 frame_err_r;
    logic [ERR_CNT_W-1:0] err_count_r;
    logic                 ready_en_r;
    logic                 s_ready_s;

    logic accept_s;
    logic fill_accept_s;
    logic at_last_s;
    logic complete_s;
    logic err_event_s;
    logic consume_s;

    assign accept_s      = s_valid & s_ready_s;
    assign fill_accept_s = accept_s & (state_r == FILL);
    assign at_last_s     = (idx_r == LAST_IDX);
    assign complete_s    = fill_accept_s & at_last_s & s_last;
    // A short frame ends early; a long frame runs past the final slot.
    assign err_event_s   = fill_accept_s & ((~at_last_s & s_last) | (at_last_s & ~s_last));
    assign consume_s     = m_valid_r & m_ready;

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign frame_err = frame_err_r;
    assign err_count = err_count_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a long frame enters DISCARD until its s_last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                if (fill_accept_s && at_last_s && !s_last) begin
                    state_nxt_s = DISCARD;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DISCARD: begin
                if (accept_s && s_last) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: state_nxt_s = FILL;
        endcase
    end

    // FSM output: stall only the completing beat while the held vector is
    // unconsumed; a same-cycle consume frees the output register in time.
    always_comb begin
        s_ready_s = 1'b0;
        if (ready_en_r && !((state_r == FILL) && at_last_s && m_valid_r && !m_ready)) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
    end

    // Keeps s_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Slot index: advances per accepted feature, restarts on any frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (fill_accept_s) begin
            if (at_last_s || s_last) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Assembly vector with the current beat merged in, so the final feature
    // can go straight to the output register on the completing edge.
    always_comb begin
        asm_nxt_s = asm_r;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            if (fill_accept_s && (idx_r == IDX_W'(k))) begin
                asm_nxt_s[k*FEAT_BITS +: FEAT_BITS] = s_data;
            end else begin
                asm_nxt_s[k*FEAT_BITS +: FEAT_BITS] = asm_r[k*FEAT_BITS +: FEAT_BITS];
            end
        end
    end

    // Assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_r <= '0;
        end else begin
            asm_r <= asm_nxt_s;
        end
    end

    // Output register: load on completion (even while consuming), else
    // drop valid on consume, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else if (complete_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= asm_nxt_s;
        end else if (consume_s) begin
            m_valid_r <= 1'b0;
            m_data_r  <= m_data_r;
        end else begin
            m_valid_r <= m_valid_r;
            m_data_r  <= m_data_r;
        end
    end

    // Framing-error flag and counter; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
            err_count_r <= '0;
        end else if (err_clr) begin
            frame_err_r <= 1'b0;
            err_count_r <= '0;
        end else if (err_event_s) begin
            frame_err_r <= 1'b1;
            err_count_r <= sat_inc(err_count_r);
        end else begin
            frame_err_r <= frame_err_r;
            err_count_r <= err_count_r;
        end
    end

endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed bench for layer0_input_packer with NUM_FEATURES=4, FEAT_BITS=2.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_layer0_input_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       frame_err;
    logic       err_clr;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    layer0_input_packer #(
        .NUM_FEATURES(4),
        .FEAT_BITS   (2),
        .ERR_CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .frame_err(frame_err),
        .err_clr  (err_clr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic       l;
        logic       mr;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_sr;
        logic       e_fe;
        logic [7:0] e_ec;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic v, input logic [1:0] d, input logic l,
                                input logic e_mv, input logic [7:0] e_md);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = 1'b1;
        r.e_mv = e_mv; r.e_md = e_md; r.e_sr = 1'b1; r.e_fe = 1'b0; r.e_ec = 8'd0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then settle for sampling.
    task automatic apply(input logic v, input logic [1:0] d, input logic l,
                         input logic mr, input logic clr);
        @(negedge clk);
        s_valid = v; s_data = d; s_last = l; m_ready = mr; err_clr = clr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 2'd0; s_last = 1'b0;
        m_ready = 1'b1; err_clr = 1'b0;

        // Single vector 1,2,3,0 -> 0x39; then back-to-back 0,1,2,3 (0xE4)
        // and 3,3,0,1 (0x4F) with no idle between beats.
        tbl[0]  = mk(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mk(1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        tbl[2]  = mk(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        tbl[3]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 8'h00);
        tbl[4]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 8'h39);
        tbl[5]  = mk(1'b1, 2'd0, 1'b0, 1'b0, 8'h39);
        tbl[6]  = mk(1'b1, 2'd1, 1'b0, 1'b0, 8'h39);
        tbl[7]  = mk(1'b1, 2'd2, 1'b0, 1'b0, 8'h39);
        tbl[8]  = mk(1'b1, 2'd3, 1'b1, 1'b0, 8'h39);
        tbl[9]  = mk(1'b1, 2'd3, 1'b0, 1'b1, 8'hE4);
        tbl[10] = mk(1'b1, 2'd3, 1'b0, 1'b0, 8'hE4);
        tbl[11] = mk(1'b1, 2'd0, 1'b0, 1'b0, 8'hE4);
        tbl[12] = mk(1'b1, 2'd1, 1'b1, 1'b0, 8'hE4);
        tbl[13] = mk(1'b0, 2'd0, 1'b0, 1'b1, 8'h4F);
        tbl[14] = mk(1'b0, 2'd0, 1'b0, 1'b0, 8'h4F);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset m_data", 32'(m_data), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single and back-to-back vectors.
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr, 1'b0);
            chk($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            chk($sformatf("row%0d m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            chk($sformatf("row%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
            chk($sformatf("row%0d frame_err", i), 32'(frame_err), 32'(tbl[i].e_fe));
            chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(tbl[i].e_ec));
        end

        // Backpressure: hold A (0x55), stall B's final beat, then release.
        for (int i = 0; i < 4; i++) apply(1'b1, 2'd1, (i == 3), 1'b0, 1'b0);
        apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("bp A held valid", 32'(m_valid), 32'd1);
        chk("bp A data", 32'(m_data), 32'h55);
        apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
            chk("bp stall s_ready", 32'(s_ready), 32'd0);
            chk("bp stall m_data", 32'(m_data), 32'h55);
            chk("bp stall m_valid", 32'(m_valid), 32'd1);
        end
        apply(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        chk("bp release s_ready", 32'(s_ready), 32'd1);
        apply(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("bp B valid no bubble", 32'(m_valid), 32'd1);
        chk("bp B data", 32'(m_data), 32'hEA);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("bp drained", 32'(m_valid), 32'd0);

        // Short frame (s_last on 2nd beat), then clean 2,0,1,3 -> 0xD2.
        apply(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("short frame_err", 32'(frame_err), 32'd1);
        chk("short err_count", 32'(err_count), 32'd1);
        chk("short no m_valid", 32'(m_valid), 32'd0);
        apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("after short m_valid", 32'(m_valid), 32'd1);
        chk("after short m_data", 32'(m_data), 32'hD2);

        // Long frame: 6 beats; error at 4th, beats 5-6 discarded.
        for (int i = 0; i < 4; i++) apply(1'b1, 2'(i), 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        chk("long err_count", 32'(err_count), 32'd2);
        chk("long s_ready", 32'(s_ready), 32'd1);
        chk("long no m_valid", 32'(m_valid), 32'd0);
        apply(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("long discard no extra err", 32'(err_count), 32'd2);
        chk("long discard no m_valid", 32'(m_valid), 32'd0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("after long m_valid", 32'(m_valid), 32'd1);
        chk("after long m_data", 32'(m_data), 32'hC0);

        // Saturation: 260 one-beat short frames on top of the 2 errors so far.
        for (int i = 0; i < 260; i++) apply(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("sat err_count", 32'(err_count), 32'd255);
        chk("sat frame_err", 32'(frame_err), 32'd1);
        chk("sat no m_valid", 32'(m_valid), 32'd0);
        // Clear coinciding with another error: the clear wins.
        apply(1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("clr err_count", 32'(err_count), 32'd0);
        chk("clr frame_err", 32'(frame_err), 32'd0);

        // Reset while a vector is held and the next one is half built.
        for (int i = 0; i < 4; i++) apply(1'b1, 2'd2, (i == 3), 1'b0, 1'b0);
        apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("pre-reset held", 32'(m_valid), 32'd1);
        chk("pre-reset data", 32'(m_data), 32'hAA);
        apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        #1;
        chk("midreset m_valid", 32'(m_valid), 32'd0);
        chk("midreset m_data", 32'(m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        chk("post-reset s_ready", 32'(s_ready), 32'd1);
        chk("post-reset no m_valid", 32'(m_valid), 32'd0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("post-reset m_valid", 32'(m_valid), 32'd1);
        chk("post-reset m_data", 32'(m_data), 32'h01);
        chk("post-reset err_count", 32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
